// File: rtl/udp_nibble_source.sv
// udp_nibble_source: periodically launches a UDP datagram (header plus a
// fill pattern) and streams it to an IP/MAC transmitter one nibble at a
// time, low nibble of each byte first, in response to fifo_rq.
module udp_nibble_source #(
  parameter int          PAYLOAD_BYTES = 20,
  parameter logic [15:0] SRC_PORT      = 16'h0521,
  parameter logic [15:0] DST_PORT      = 16'h2715,
  parameter int          INTERVAL      = 16777216,
  parameter logic [7:0]  SEED          = 8'h00
) (
  input  logic        mii_tx_clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pattern_mode,
  input  logic        fifo_rq,
  output logic [3:0]  fifo_da,
  output logic        tx_go,
  output logic [11:0] data_len,
  output logic        busy,
  output logic [15:0] pkt_cnt
);

  localparam int          TOTAL_BYTES = 8 + PAYLOAD_BYTES;
  localparam int          NIBBLES     = 2 * TOTAL_BYTES;
  localparam int          IDX_W       = $clog2(NIBBLES + 1);
  localparam int          BS_W        = IDX_W - 1;
  localparam logic [11:0] LEN         = 12'(TOTAL_BYTES);
  localparam logic [23:0] WRAP_AT     = 24'(INTERVAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    READING
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [23:0]       cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              tx_go_q, tx_go_d;
  logic [31:0]       seq_cnt_q, seq_cnt_d;
  logic [31:0]       seq_latched_q, seq_latched_d;
  logic              mode_q, mode_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [3:0]        fifo_da_q, fifo_da_d;

  logic [BS_W-1:0]   byte_sel;
  logic [95:0]       hdr;
  logic [3:0]        hdr_pos;
  logic [7:0]        pay_j;
  logic [7:0]        byte_val;
  logic [3:0]        nib;
  logic              wrap;
  logic              issue;

  // Pick the byte addressed by the nibble index: 12 header bytes, then fill pattern.
  always_comb begin
    byte_sel = idx_q[IDX_W-1:1];
    hdr      = {SRC_PORT, DST_PORT, 4'h0, LEN, 16'h0000, seq_latched_q};
    hdr_pos  = 4'd11 - byte_sel[3:0];
    pay_j    = 8'(byte_sel) - 8'd12;
    byte_val = 8'h00;
    if (byte_sel < BS_W'(12)) begin
      byte_val = hdr[{hdr_pos, 3'b000} +: 8];
    end else if (mode_q) begin
      byte_val = SEED;
    end else begin
      byte_val = SEED + pay_j;
    end
    nib = idx_q[0] ? byte_val[7:4] : byte_val[3:0];
  end

  // Next-state logic for the interval timer, launch handshake, sequencing and read-out FSM.
  always_comb begin
    wrap  = en && (cnt_q == WRAP_AT);
    issue = en && pending_q && !fifo_rq && (state_q == IDLE);

    cnt_d = cnt_q + 24'd1;
    if (!en || wrap) begin
      cnt_d = 24'd0;
    end

    pending_d = pending_q;
    if (!en || issue) begin
      pending_d = 1'b0;
    end else if (wrap) begin
      pending_d = 1'b1;
    end

    tx_go_d       = issue;
    seq_cnt_d     = issue ? seq_cnt_q + 32'd1 : seq_cnt_q;
    seq_latched_d = issue ? seq_cnt_q : seq_latched_q;
    mode_d        = issue ? pattern_mode : mode_q;

    idx_d = '0;
    if (fifo_rq) begin
      idx_d = (idx_q < IDX_W'(NIBBLES)) ? idx_q + IDX_W'(1) : idx_q;
    end

    fifo_da_d = 4'h0;
    if (fifo_rq && (idx_q < IDX_W'(NIBBLES))) begin
      fifo_da_d = nib;
    end

    state_d   = state_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      IDLE:    if (issue) state_d = ARMED;
      ARMED:   if (fifo_rq) state_d = READING;
      READING: begin
        if (!fifo_rq) begin
          state_d   = IDLE;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers; reset aborts any packet and restarts the interval from zero.
  always_ff @(posedge mii_tx_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= 24'd0;
      pending_q     <= 1'b0;
      tx_go_q       <= 1'b0;
      seq_cnt_q     <= 32'd0;
      seq_latched_q <= 32'd0;
      mode_q        <= 1'b0;
      pkt_cnt_q     <= 16'd0;
      fifo_da_q     <= 4'h0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      tx_go_q       <= tx_go_d;
      seq_cnt_q     <= seq_cnt_d;
      seq_latched_q <= seq_latched_d;
      mode_q        <= mode_d;
      pkt_cnt_q     <= pkt_cnt_d;
      fifo_da_q     <= fifo_da_d;
    end
  end

  assign fifo_da  = fifo_da_q;
  assign tx_go    = tx_go_q;
  assign busy     = (state_q != IDLE);
  assign pkt_cnt  = pkt_cnt_q;
  assign data_len = LEN;

endmodule

// File: tb/tb_udp_nibble_source.sv
// Bench for udp_nibble_source: a table of packet scenarios drives a simple
// transmitter model, with expected nibbles queued as requests are issued,
// plus hand-written sequences for enable drop, idle streaming and reset.
module tb_udp_nibble_source;

  localparam int         PAYLOAD   = 20;
  localparam int         INTERVAL  = 8;
  localparam logic [7:0] SEED      = 8'hA5;
  localparam int         TOTAL_NIB = 2 * (8 + PAYLOAD);

  logic        mii_tx_clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pattern_mode;
  logic        fifo_rq;
  logic [3:0]  fifo_da;
  logic        tx_go;
  logic [11:0] data_len;
  logic        busy;
  logic [15:0] pkt_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] nib;
    int         idx;
  } exp_t;

  exp_t        expQueue[$];
  int          modelIdx;
  logic [31:0] modelSeq;
  bit          modelMode;

  typedef struct {
    int          rqCycles;
    bit          mode;
    int          toggleAt;
    int          expWait;
    logic [31:0] expSeq;
    logic [15:0] expPkt;
  } vec_t;

  vec_t vecs[6];

  udp_nibble_source #(
    .PAYLOAD_BYTES(PAYLOAD),
    .SRC_PORT(16'h0521),
    .DST_PORT(16'h2715),
    .INTERVAL(INTERVAL),
    .SEED(SEED)
  ) dut (
    .mii_tx_clk(mii_tx_clk),
    .rst(rst),
    .en(en),
    .pattern_mode(pattern_mode),
    .fifo_rq(fifo_rq),
    .fifo_da(fifo_da),
    .tx_go(tx_go),
    .data_len(data_len),
    .busy(busy),
    .pkt_cnt(pkt_cnt)
  );

  // Free-running transmit clock.
  always #5 mii_tx_clk = ~mii_tx_clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference datagram: header bytes written out by hand, then the fill pattern.
  function automatic logic [3:0] expNibble(input int k, input logic [31:0] seq, input bit mode);
    logic [7:0] hdr [12];
    logic [7:0] byteVal;
    int b;
    if (k >= TOTAL_NIB) return 4'h0;
    hdr = '{8'h05, 8'h21, 8'h27, 8'h15, 8'h00, 8'h1C, 8'h00, 8'h00,
            seq[31:24], seq[23:16], seq[15:8], seq[7:0]};
    b = k / 2;
    if (b < 12) byteVal = hdr[b];
    else if (mode) byteVal = SEED;
    else byteVal = 8'(int'(SEED) + (b - 12));
    return (k % 2 == 1) ? byteVal[7:4] : byteVal[3:0];
  endfunction

  // Advance to the next falling edge and retire one queued expectation.
  task automatic tick();
    exp_t e;
    @(negedge mii_tx_clk);
    if (expQueue.size() > 0) begin
      e = expQueue.pop_front();
      checkOutput($sformatf("fifo_da[%0d]", e.idx), fifo_da, e.nib);
    end
  endtask

  task automatic applyStimulus(input bit rq);
    exp_t e;
    fifo_rq = rq;
    if (rq) begin
      e.nib = expNibble(modelIdx, modelSeq, modelMode);
      e.idx = modelIdx;
      modelIdx++;
    end else begin
      e.nib = 4'h0;
      e.idx = -1;
      modelIdx = 0;
    end
    expQueue.push_back(e);
  endtask

  task automatic waitTxGo(input string name, input int expWait);
    int n = 0;
    bit seen = 0;
    fifo_rq = 1'b0;
    modelIdx = 0;
    while (!seen && n < 300) begin
      tick();
      n++;
      if (tx_go === 1'b1) seen = 1;
    end
    if (!seen) begin
      checkOutput({name, " tx_go timeout"}, 32'(seen), 32'd1);
    end else begin
      if (expWait >= 0) checkOutput({name, " tx_go wait"}, 32'(n), 32'(expWait));
      checkOutput({name, " busy at tx_go"}, 32'(busy), 32'd1);
    end
  endtask

  task automatic runPacket(input string name, input int n, input int toggleAt,
                           input logic [31:0] expSeq, input bit mode, input logic [15:0] expPkt);
    modelSeq  = expSeq;
    modelMode = mode;
    modelIdx  = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1);
      if (i == toggleAt) pattern_mode = ~pattern_mode;
      tick();
      if (i == 0) checkOutput({name, " tx_go single cycle"}, 32'(tx_go), 32'd0);
    end
    checkOutput({name, " busy while reading"}, 32'(busy), 32'd1);
    applyStimulus(1'b0);
    tick();
    checkOutput({name, " busy after rq falls"}, 32'(busy), 32'd0);
    checkOutput({name, " pkt_cnt"}, 32'(pkt_cnt), 32'(expPkt));
    checkOutput({name, " tx_go after packet"}, 32'(tx_go), 32'd0);
  endtask

  // Main test sequence.
  initial begin
    int goCount;

    vecs[0] = '{rqCycles: 56, mode: 1'b0, toggleAt: -1, expWait: 9,  expSeq: 32'd0, expPkt: 16'd1};
    vecs[1] = '{rqCycles: 56, mode: 1'b0, toggleAt: -1, expWait: 1,  expSeq: 32'd1, expPkt: 16'd2};
    vecs[2] = '{rqCycles: 56, mode: 1'b1, toggleAt: 30, expWait: 1,  expSeq: 32'd2, expPkt: 16'd3};
    vecs[3] = '{rqCycles: 60, mode: 1'b0, toggleAt: -1, expWait: 1,  expSeq: 32'd3, expPkt: 16'd4};
    vecs[4] = '{rqCycles: 3,  mode: 1'b0, toggleAt: -1, expWait: 1,  expSeq: 32'd4, expPkt: 16'd5};
    vecs[5] = '{rqCycles: 10, mode: 1'b1, toggleAt: -1, expWait: -1, expSeq: 32'd5, expPkt: 16'd6};

    rst = 1'b1;
    en = 1'b0;
    pattern_mode = 1'b0;
    fifo_rq = 1'b0;
    modelIdx = 0;
    repeat (3) tick();
    checkOutput("reset fifo_da", 32'(fifo_da), 32'd0);
    checkOutput("reset tx_go", 32'(tx_go), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset pkt_cnt", 32'(pkt_cnt), 32'd0);
    checkOutput("data_len", 32'(data_len), 32'd28);

    rst = 1'b0;
    en = 1'b1;
    for (int v = 0; v < 6; v++) begin
      pattern_mode = vecs[v].mode;
      waitTxGo($sformatf("vec%0d", v), vecs[v].expWait);
      runPacket($sformatf("vec%0d", v), vecs[v].rqCycles, vecs[v].toggleAt,
                vecs[v].expSeq, vecs[v].mode, vecs[v].expPkt);
    end

    // A launch is pending here; dropping en must cancel it.
    en = 1'b0;
    goCount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tx_go === 1'b1) goCount++;
    end
    checkOutput("en=0 cancels launch", 32'(goCount), 32'd0);

    // Requests while idle stream the last packet's header without touching busy/pkt_cnt.
    modelSeq = 32'd5;
    modelMode = 1'b1;
    modelIdx = 0;
    for (int i = 0; i < 28; i++) begin
      applyStimulus(1'b1);
      tick();
    end
    checkOutput("idle stream busy", 32'(busy), 32'd0);
    applyStimulus(1'b0);
    tick();
    checkOutput("idle stream pkt_cnt", 32'(pkt_cnt), 32'd6);

    en = 1'b1;
    pattern_mode = 1'b0;
    waitTxGo("re-enable", INTERVAL + 1);

    // Abort late in the header so fifo_da holds a nonzero nibble when reset hits.
    modelSeq = 32'd6;
    modelMode = 1'b0;
    modelIdx = 0;
    for (int i = 0; i < 23; i++) begin
      applyStimulus(1'b1);
      tick();
    end
    rst = 1'b1;
    #1;
    checkOutput("mid-packet reset fifo_da", 32'(fifo_da), 32'd0);
    checkOutput("mid-packet reset busy", 32'(busy), 32'd0);
    checkOutput("mid-packet reset pkt_cnt", 32'(pkt_cnt), 32'd0);
    checkOutput("mid-packet reset tx_go", 32'(tx_go), 32'd0);
    fifo_rq = 1'b0;
    expQueue.delete();
    tick();
    rst = 1'b0;
    waitTxGo("post-reset", INTERVAL + 1);
    runPacket("post-reset", 56, -1, 32'd0, 1'b0, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
